fifo_v4: RTL
============

FIFO_V4 -- requirements
Module: fifo_v4

Interface
REQ-001 SHALL have parameter FALL_THROUGH, default 1'b0, enabling same-cycle bypass from data_i to data_o when empty.
REQ-002 SHALL have parameter DEPTH, default 8, entry count; any value >= 1, power of two not required.
REQ-003 SHALL have parameter dtype, default logic [31:0], entry type.
REQ-004 SHALL have parameter ALM_FULL_TH, default DEPTH-1, almost-full threshold in entries.
REQ-005 SHALL have parameter ALM_EMPTY_TH, default 1, almost-empty threshold in entries.
REQ-006 SHALL have ports: clk_i  in  1  clock; rst_ni  in  1  reset.
REQ-007 SHALL have flush_i  in  1  synchronous clear; testmode_i  in  1  test mode, no functional effect.
REQ-008 SHALL have data_i  in  dtype  write data; push_i  in  1  write request; pop_i  in  1  read request.
REQ-009 SHALL have data_o  out  dtype  head entry; full_o  out  1; empty_o  out  1.
REQ-010 SHALL have alm_full_o  out  1  usage >= ALM_FULL_TH; alm_empty_o  out  1  usage <= ALM_EMPTY_TH.
REQ-011 SHALL have usage_o  out  CNT_WIDTH  stored entries, CNT_WIDTH = $clog2(DEPTH+1).
REQ-012 SHALL have overflow_o  out  1 and underflow_o  out  1  sticky error flags.
REQ-013 Reset SHALL be asynchronous, active-low on rst_ni; single clock clk_i.

Function
REQ-014 full_o SHALL be 1 iff usage == DEPTH; empty_o SHALL be 1 iff usage == 0, except REQ-018.
REQ-015 Push SHALL be accepted iff push_i && (!full_o || pop_i); write lands at write pointer, visible on data_o next cycle when it becomes head.
REQ-016 Pop SHALL be accepted iff pop_i && !empty_o; read pointer advances at clock edge.
REQ-017 Accepted push and pop in same cycle SHALL leave usage unchanged, both pointers advance, including at full.
REQ-018 FALL_THROUGH=1 and usage==0 and push_i: empty_o SHALL be 0 and data_o SHALL equal data_i combinationally; with pop_i also high, entry SHALL bypass, usage stays 0.
REQ-019 Pointers SHALL wrap from DEPTH-1 to 0 for any DEPTH.
REQ-020 push_i while full and !pop_i SHALL be dropped, state unchanged, overflow_o set.
REQ-021 pop_i while empty with no fall-through bypass SHALL be ignored, underflow_o set.
REQ-022 flush_i SHALL have priority over push/pop: pointers, usage and error flags cleared next edge; concurrent push dropped without error.
REQ-023 alm_full_o and alm_empty_o SHALL be combinational from registered usage.
REQ-024 Latency non-fall-through: push to data_o/!empty_o SHALL be exactly 1 cycle.

Reset
REQ-025 On rst_ni low: usage 0, pointers 0, storage 0, empty_o 1, full_o 0, alm_empty_o 1, alm_full_o 0 (ALM_FULL_TH>0), data_o 0, error flags 0.
REQ-026 Reset mid-operation SHALL discard all contents immediately, asynchronously.

Configuration
REQ-027 Macro FIFO_V4_ERR_FLAGS_EN defined: overflow_o/underflow_o behave per REQ-020/021/022.
REQ-028 Macro undefined: overflow_o and underflow_o SHALL be tied 0, no flag registers synthesised; drop/ignore behaviour unchanged.

Structure
REQ-029 Shared package fifo_pkg SHALL hold cnt_width() function and fifo_err_t (overflow, underflow) struct; axi_math_pkg reused for is_pow2.
REQ-030 One sub-module fifo_v4_ptr SHALL implement a wrap-at-DEPTH pointer with increment and clear; instantiated twice.
REQ-031 Elaboration SHALL error if DEPTH==0, ALM_FULL_TH>DEPTH or ALM_EMPTY_TH>DEPTH.

Verification
REQ-032 DEPTH=5: push 0..4 -> full_o=1 and usage_o=5 after 5th edge; pop 5 -> data_o 0,1,2,3,4, empty_o=1.
REQ-033 DEPTH=5 full, push 0xA5 and pop same cycle -> usage 5, head advances, 0xA5 popped last; wrap exercised past index 4.
REQ-034 FALL_THROUGH=1 empty, push 0x11 with pop -> data_o=0x11 same cycle, usage stays 0, empty_o 1 next cycle.
REQ-035 Macro defined, full, push no pop -> overflow_o=1 held; flush_i pulse -> usage 0, overflow_o 0; same on empty pop -> underflow_o.
REQ-036 DEPTH=8, ALM_FULL_TH=6, ALM_EMPTY_TH=2: push 6 -> alm_full_o rises on 6th; pop 4 -> alm_empty_o rises at usage 2.
REQ-037 rst_ni low with usage 3 mid-burst -> all outputs at REQ-025 values without clock edge.

Source files
------------

// File: rtl/axi_math_pkg.sv
// axi_math_pkg: shared integer helpers used at elaboration time.
//   is_pow2(n) : 1 when n is a positive power of two.
package axi_math_pkg;

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_pkg.sv
// fifo_pkg: types and helpers shared by the fifo_v4 family.
//   cnt_width(depth) : bits needed to hold an occupancy of 0..depth.
//   fifo_err_t       : sticky overflow/underflow flag pair.
package fifo_pkg;

    typedef struct packed {
        logic overflow;
        logic underflow;
    } fifo_err_t;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_v4_ptr.sv
// fifo_v4_ptr: circular index that wraps from DEPTH-1 back to 0.
// Ports:
//   clk_i  - clock
//   rst_ni - asynchronous active-low reset
//   clr_i  - synchronous clear to 0 (wins over inc_i)
//   inc_i  - advance by one
//   ptr_o  - current index
module fifo_v4_ptr
    import axi_math_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [PTR_W-1:0] ptr_o
);

    // Power-of-two depths wrap by natural overflow, so the end compare drops out.
    localparam bit              NAT_WRAP = is_pow2(DEPTH) && (DEPTH > 1);
    localparam logic [PTR_W-1:0] LAST    = PTR_W'(DEPTH - 1);

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_next;

    assign w_next = (NAT_WRAP || r_ptr != LAST) ? r_ptr + PTR_W'(1) : '0;
    assign ptr_o  = r_ptr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)    r_ptr <= '0;
        else if (clr_i) r_ptr <= '0;
        else if (inc_i) r_ptr <= w_next;
    end

endmodule

// File: rtl/fifo_v4.sv
// fifo_v4: synchronous FIFO with optional fall-through and almost flags.
// Ports:
//   clk_i, rst_ni       - clock, asynchronous active-low reset
//   flush_i             - synchronous clear of pointers, usage and error flags
//   testmode_i          - no functional effect
//   data_i/push_i/pop_i - write data, write request, read request
//   data_o              - head entry (data_i when bypassing in fall-through mode)
//   full_o/empty_o      - occupancy status
//   alm_full_o          - usage >= ALM_FULL_TH
//   alm_empty_o         - usage <= ALM_EMPTY_TH
//   usage_o             - number of stored entries
//   overflow_o          - sticky: push dropped while full
//   underflow_o         - sticky: pop while empty
// Macro FIFO_V4_ERR_FLAGS_EN enables the sticky error flags; when undefined
// both flag outputs are tied low and no flag registers exist.
module fifo_v4
    import fifo_pkg::*;
#(
    parameter bit   FALL_THROUGH = 1'b0,
    parameter int   DEPTH        = 8,
    parameter type  dtype        = logic [31:0],
    parameter int   ALM_FULL_TH  = DEPTH - 1,
    parameter int   ALM_EMPTY_TH = 1,
    localparam int  CNT_WIDTH    = cnt_width(DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 testmode_i,
    input  dtype                 data_i,
    input  logic                 push_i,
    input  logic                 pop_i,
    output dtype                 data_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic                 alm_full_o,
    output logic                 alm_empty_o,
    output logic [CNT_WIDTH-1:0] usage_o,
    output logic                 overflow_o,
    output logic                 underflow_o
);

    localparam int                   PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_WIDTH-1:0] L_FULL = CNT_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] L_AF   = CNT_WIDTH'(ALM_FULL_TH);
    localparam logic [CNT_WIDTH-1:0] L_AE   = CNT_WIDTH'(ALM_EMPTY_TH);

    if (DEPTH < 1 || ALM_FULL_TH > DEPTH || ALM_EMPTY_TH > DEPTH) begin : g_param_err
        $error("fifo_v4: DEPTH must be >= 1 and thresholds must not exceed DEPTH");
    end

    dtype                 r_mem [DEPTH];
    logic [CNT_WIDTH-1:0] r_usage;
    logic [PTR_W-1:0]     w_rd_ptr;
    logic [PTR_W-1:0]     w_wr_ptr;
    logic                 w_empty_q;
    logic                 w_full_q;
    logic                 w_show;
    logic                 w_bypass;
    logic                 w_push_ok;
    logic                 w_pop_ok;
    logic                 w_unused;

    assign w_unused  = testmode_i;
    assign w_empty_q = (r_usage == '0);
    assign w_full_q  = (r_usage == L_FULL);
    // Fall-through: an empty FIFO presents the incoming word directly; if it is
    // popped in the same cycle it never enters storage.
    assign w_show    = FALL_THROUGH && w_empty_q && push_i;
    assign w_bypass  = w_show && pop_i;
    assign w_push_ok = push_i && !flush_i && (!w_full_q || pop_i) && !w_bypass;
    assign w_pop_ok  = pop_i && !flush_i && !w_empty_q;

    assign data_o      = w_show ? data_i : r_mem[w_rd_ptr];
    assign empty_o     = w_empty_q && !w_show;
    assign full_o      = w_full_q;
    assign alm_full_o  = (r_usage >= L_AF);
    assign alm_empty_o = (r_usage <= L_AE);
    assign usage_o     = r_usage;

    fifo_v4_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wr_ptr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (flush_i),
        .inc_i  (w_push_ok),
        .ptr_o  (w_wr_ptr)
    );

    fifo_v4_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rd_ptr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (flush_i),
        .inc_i  (w_pop_ok),
        .ptr_o  (w_rd_ptr)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)        r_usage <= '0;
        else if (flush_i)   r_usage <= '0;
        else                r_usage <= r_usage + CNT_WIDTH'(w_push_ok) - CNT_WIDTH'(w_pop_ok);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)        r_mem <= '{default: '0};
        else if (w_push_ok) r_mem[w_wr_ptr] <= data_i;
    end

`ifdef FIFO_V4_ERR_FLAGS_EN
    fifo_err_t r_err;
    logic      w_ovf;
    logic      w_udf;

    assign w_ovf       = push_i && w_full_q && !pop_i && !flush_i;
    assign w_udf       = pop_i && w_empty_q && !w_bypass && !flush_i;
    assign overflow_o  = r_err.overflow;
    assign underflow_o = r_err.underflow;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)      r_err <= '0;
        else if (flush_i) r_err <= '0;
        else begin
            r_err.overflow  <= r_err.overflow | w_ovf;
            r_err.underflow <= r_err.underflow | w_udf;
        end
    end
`else
    assign overflow_o  = 1'b0;
    assign underflow_o = 1'b0;
`endif

endmodule
